// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM state encoding, address-field width helpers and AXI burst lengths.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_MISS_R,
        S_RESP
    } state_t;

    // Single-beat AXI burst (arlen is beats minus one)
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // Byte-offset field width: word select plus the two byte bits
    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    // Line index width; zero for a single-line cache
    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Remaining upper address bits form the tag
    function automatic int tag_w(input int num_lines, input int words_per_line);
        return 32 - offset_w(words_per_line) - index_w(num_lines);
    endfunction

    // Burst length for a whole-line refill
    function automatic logic [7:0] fill_len(input int words_per_line);
        return 8'(words_per_line - 1);
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped instruction cache.
// Combinational indexed read, one write port, and a flush that clears
// every valid bit in a single cycle and takes priority over a write.
module icache_tag_array #(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];

    // Valid bits: cleared by reset or flush, set when a line fill completes
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag storage carries no reset; a tag is only meaningful under its valid bit
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];

endmodule

// File: rtl/icache_dm_multi.sv
// Direct-mapped instruction cache, NUM_LINES lines of WORDS_PER_LINE words.
// Misses refill a whole line with an incrementing AXI burst; addresses whose
// top byte equals BYPASS_TAG are passed through as single-beat reads.
// A rising edge on fence_i_i invalidates every line.
// Optional build macro ICACHE_PERF_EN adds hit/miss/bypass counters.
module icache_dm_multi
    import icache_pkg::*;
#(
    parameter int         NUM_LINES      = 4,
    parameter int         WORDS_PER_LINE = 4,
    parameter logic [7:0] BYPASS_TAG     = 8'h0f
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fence_i_i,
    input  logic        cpu_arvalid_i,
    output logic        cpu_arready_o,
    input  logic [31:0] cpu_araddr_i,
    output logic        cpu_rvalid_o,
    input  logic        cpu_rready_i,
    output logic [31:0] cpu_rdata_o,
    output logic        axi_arvalid_o,
    input  logic        axi_arready_i,
    output logic [31:0] axi_araddr_o,
    output logic [7:0]  axi_arlen_o,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o,
    input  logic [31:0] axi_rdata_i,
    input  logic        axi_rlast_i,
`ifdef ICACHE_PERF_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
    output logic [31:0] bypass_cnt_o,
`endif
    output logic        icache_flush_done_o
);

    localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
    localparam int INDEX_W  = index_w(NUM_LINES);
    localparam int TAG_W    = tag_w(NUM_LINES, WORDS_PER_LINE);
    localparam int IDX_W    = (INDEX_W > 0) ? INDEX_W : 1;
    localparam int WORD_W   = OFFSET_W - 2;
    localparam int DA_W     = IDX_W + WORD_W;

    state_t              state;
    logic                fence_d;
    logic                fence_pulse;
    logic                flush_pending;
    logic [31:0]         req_addr;
    logic                req_bypass;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [WORD_W-1:0]   req_word;
    logic [WORD_W-1:0]   beat_cnt;
    logic [31:0]         resp_data;
    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic                hit;
    logic                req_fire;
    logic                beat_fire;
    logic                fill_done;
    logic                tag_wr_en;
    logic [DA_W-1:0]     rd_addr;
    logic [DA_W-1:0]     wr_addr;
    logic [31:0]         data_mem [NUM_LINES*WORDS_PER_LINE];

    // Address fields of the latched request
    assign req_tag  = req_addr[31 -: TAG_W];
    assign req_word = req_addr[OFFSET_W-1:2];

    generate
        if (INDEX_W > 0) begin : g_idx
            assign req_idx = req_addr[OFFSET_W +: IDX_W];
        end else begin : g_no_idx
            assign req_idx = '0;
        end
    endgenerate

    assign fence_pulse         = fence_i_i & ~fence_d;
    assign icache_flush_done_o = fence_pulse;

    assign cpu_arready_o = (state == S_IDLE) & ~fence_i_i;
    assign cpu_rdata_o   = resp_data;

    assign req_fire  = cpu_arvalid_i & cpu_arready_o;
    assign hit       = ~req_bypass & line_valid & (line_tag == req_tag);
    assign beat_fire = (state == S_MISS_R) & axi_rvalid_i & axi_rready_o;
    assign fill_done = beat_fire & (req_bypass | axi_rlast_i);

    // A fence seen during the fill (or on its last beat) keeps the line invalid
    assign tag_wr_en = fill_done & ~req_bypass & ~flush_pending & ~fence_pulse;

    assign rd_addr = {req_idx, req_word};
    assign wr_addr = {req_idx, beat_cnt};

    icache_tag_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .flush    (fence_pulse),
        .rd_idx   (req_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .wr_en    (tag_wr_en),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag)
    );

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            fence_d       <= 1'b0;
            flush_pending <= 1'b0;
            beat_cnt      <= '0;
            axi_arvalid_o <= 1'b0;
            axi_rready_o  <= 1'b0;
            cpu_rvalid_o  <= 1'b0;
        end else begin
            fence_d <= fence_i_i;

            if (fill_done) begin
                flush_pending <= 1'b0;
            end else if (fence_pulse && (state == S_MISS_AR || state == S_MISS_R)) begin
                flush_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (req_fire) begin
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        cpu_rvalid_o <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        axi_arvalid_o <= 1'b1;
                        state         <= S_MISS_AR;
                    end
                end
                S_MISS_AR: begin
                    if (axi_arready_i) begin
                        axi_arvalid_o <= 1'b0;
                        axi_rready_o  <= 1'b1;
                        beat_cnt      <= '0;
                        state         <= S_MISS_R;
                    end
                end
                S_MISS_R: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + WORD_W'(1);
                        if (fill_done) begin
                            axi_rready_o <= 1'b0;
                            cpu_rvalid_o <= 1'b1;
                            state        <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (cpu_rready_i) begin
                        cpu_rvalid_o <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: request latch, AXI address/len, line data and response buffer
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_fire) begin
            req_addr   <= cpu_araddr_i;
            req_bypass <= (cpu_araddr_i[31:24] == BYPASS_TAG);
        end
        if (state == S_LOOKUP) begin
            resp_data    <= data_mem[rd_addr];
            axi_araddr_o <= req_bypass ? req_addr
                                       : {req_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            axi_arlen_o  <= req_bypass ? LEN_SINGLE : fill_len(WORDS_PER_LINE);
        end
        if (beat_fire) begin
            if (!req_bypass) begin
                data_mem[wr_addr] <= axi_rdata_i;
            end
            if (req_bypass || beat_cnt == req_word) begin
                resp_data <= axi_rdata_i;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] bypass_cnt;

    // Lookup outcome counters survive reset and flush, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (state == S_LOOKUP) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else if (req_bypass) begin
                bypass_cnt <= bypass_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o    = hit_cnt;
    assign miss_cnt_o   = miss_cnt;
    assign bypass_cnt_o = bypass_cnt;
`endif

endmodule
